// File: rtl/motion_pkg.sv
// motion_pkg: encodings shared between the maze controller and the car-side
// motion executor.
//   - Command state codes (MOVE / TURN / WAIT), same encoding as the
//     controller's next_state.
//   - One-hot direction codes (FRONT / BACK / RIGHT / LEFT).
//   - Absolute heading enum (N / E / S / W).
//   - Executor FSM states.
//   - Default tick constants.
//   - Helpers for command legality and heading step.
package motion_pkg;

    localparam logic [1:0] MOVE = 2'b10;
    localparam logic [1:0] TURN = 2'b01;
    localparam logic [1:0] WAIT = 2'b00;

    localparam logic [3:0] FRONT = 4'b0001;
    localparam logic [3:0] BACK  = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b1000;

    localparam int DEF_TICK_DIV   = 2000000;  // 20 ms at 100 MHz
    localparam int DEF_TURN_TICKS = 5;
    localparam int DEF_MOVE_TICKS = 3;
    localparam int DEF_WAIT_TICKS = 1;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_E = 2'd1,
        HEAD_S = 2'd2,
        HEAD_W = 2'd3
    } heading_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN_TURN,
        RUN_MOVE,
        RUN_WAIT
    } exec_state_e;

    // A command is legal when its state code is defined and exactly one
    // direction bit is set.
    function automatic logic cmd_is_legal(input logic [1:0] st, input logic [3:0] dir);
        return (st != 2'b11) && $onehot(dir);
    endfunction

    // Heading change (mod 4) produced by a completed turn in direction dir.
    function automatic logic [1:0] heading_step(input logic [3:0] dir);
        logic [1:0] step;
        case (dir)
            RIGHT:   step = 2'd1;
            LEFT:    step = 2'd3;
            BACK:    step = 2'd2;
            default: step = 2'd0;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/motion_executor_tick_gen.sv
// tick_gen: free-running motion-tick divider.
// Emits a one-cycle tick every TICK_DIV cycles. The restart input forces the
// divider back to 0 on the next edge, so the first tick after a restart comes
// exactly TICK_DIV cycles later.
// Ports:
//   sys_clk - system clock
//   rst     - asynchronous active-high reset
//   restart - clear the divider on the next edge
//   tick    - high during the last cycle of each TICK_DIV-cycle period
module tick_gen
    import motion_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign tick = (div_q == DIV_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (restart || tick) begin
            div_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/motion_executor.sv
// motion_executor: car-side consumer of the maze controller's command stream.
// Accepts one (state, direction) command at a time, drives the motor outputs
// for N motion ticks, pulses done in the final drive cycle, and keeps the
// absolute heading.
// Optional feature: define MOTION_QUEUE_EN to add a one-entry command buffer
// so a new command can be accepted while one is executing.
// Ports:
//   sys_clk, rst                 - clock, asynchronous active-high reset
//   cmd_valid, cmd_state,cmd_dir - command offer (state code, one-hot dir)
//   cmd_ready                    - command accepted on edges with valid&&ready
//   drv_fwd/back/left/right      - motor control, at most one high
//   busy                         - executing a command
//   done                         - pulse in the last cycle of a command
//   cmd_err                      - pulse one cycle after an illegal command
//   heading                      - 0 N, 1 E, 2 S, 3 W
module motion_executor
    import motion_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int TURN_TICKS = DEF_TURN_TICKS,
    parameter int MOVE_TICKS = DEF_MOVE_TICKS,
    parameter int WAIT_TICKS = DEF_WAIT_TICKS
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_state,
    input  logic [3:0] cmd_dir,
    output logic       cmd_ready,
    output logic       drv_fwd,
    output logic       drv_back,
    output logic       drv_left,
    output logic       drv_right,
    output logic       busy,
    output logic       done,
    output logic       cmd_err,
    output logic [1:0] heading
);

    // Tick counter must hold the longest command length.
    localparam int MAX_A     = (2 * TURN_TICKS > MOVE_TICKS) ? 2 * TURN_TICKS : MOVE_TICKS;
    localparam int MAX_TICKS = (MAX_A > WAIT_TICKS) ? MAX_A : WAIT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Command length in ticks; a front turn is zero-length.
    function automatic cnt_t ticks_for(input logic [1:0] st, input logic [3:0] dir);
        cnt_t n;
        case (st)
            TURN: begin
                if (dir == BACK)       n = cnt_t'(2 * TURN_TICKS);
                else if (dir == FRONT) n = '0;
                else                   n = cnt_t'(TURN_TICKS);
            end
            MOVE:    n = cnt_t'(MOVE_TICKS);
            default: n = cnt_t'(WAIT_TICKS);
        endcase
        return n;
    endfunction

    function automatic exec_state_e run_state_for(input logic [1:0] st);
        case (st)
            TURN:    return RUN_TURN;
            MOVE:    return RUN_MOVE;
            default: return RUN_WAIT;
        endcase
    endfunction

    exec_state_e state_q, state_d;
    logic [3:0]  dir_q, dir_d;
    cnt_t        n_q, n_d;
    cnt_t        cnt_q, cnt_d;
    heading_e    heading_q, heading_d;
    logic        err_q, err_d;

    logic        tick, running, last, accept, legal, start;
    logic [1:0]  start_state;
    logic [3:0]  start_dir;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .restart (start),
        .tick    (tick)
    );

    assign accept  = cmd_valid && cmd_ready;
    assign legal   = cmd_is_legal(cmd_state, cmd_dir);
    assign running = (state_q != IDLE);
    // Zero-length commands finish in their first RUN cycle; otherwise the
    // command ends on its N-th tick.
    assign last    = running && ((n_q == '0) || (tick && (cnt_q == n_q - cnt_t'(1))));

`ifdef MOTION_QUEUE_EN
    logic       buf_valid_q, buf_valid_d;
    logic [1:0] buf_state_q, buf_state_d;
    logic [3:0] buf_dir_q, buf_dir_d;

    assign cmd_ready = !buf_valid_q;

    // A buffered command takes priority and starts as soon as the executor is
    // free (including the edge that ends the current command). A new legal
    // command starts directly when idle, otherwise it goes into the buffer.
    always_comb begin
        start       = 1'b0;
        start_state = cmd_state;
        start_dir   = cmd_dir;
        buf_valid_d = buf_valid_q;
        buf_state_d = buf_state_q;
        buf_dir_d   = buf_dir_q;
        if (buf_valid_q && (!running || last)) begin
            start       = 1'b1;
            start_state = buf_state_q;
            start_dir   = buf_dir_q;
            buf_valid_d = 1'b0;
        end else if (accept && legal) begin
            if (running) begin
                buf_valid_d = 1'b1;
                buf_state_d = cmd_state;
                buf_dir_d   = cmd_dir;
            end else begin
                start = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_state_q <= WAIT;
            buf_dir_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_state_q <= buf_state_d;
            buf_dir_q   <= buf_dir_d;
        end
    end
`else
    assign cmd_ready   = (state_q == IDLE);
    assign start       = accept && legal;
    assign start_state = cmd_state;
    assign start_dir   = cmd_dir;
`endif

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        heading_d = heading_q;
        err_d     = accept && !legal;
        if (running) begin
            if (tick) begin
                cnt_d = cnt_q + cnt_t'(1);
            end
            if (last) begin
                state_d = IDLE;
                if (state_q == RUN_TURN) begin
                    heading_d = heading_e'(heading_q + heading_step(dir_q));
                end
            end
        end
        if (start) begin
            state_d = run_state_for(start_state);
            dir_d   = start_dir;
            n_d     = ticks_for(start_state, start_dir);
            cnt_d   = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            heading_q <= HEAD_N;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            heading_q <= heading_d;
            err_q     <= err_d;
        end
    end

    // Drive outputs decode the registered state only, so reset drops them
    // asynchronously.
    assign drv_left  = (state_q == RUN_TURN) && (dir_q == LEFT);
    assign drv_right = (state_q == RUN_TURN) && ((dir_q == RIGHT) || (dir_q == BACK));
    assign drv_back  = (state_q == RUN_MOVE) && (dir_q == BACK);
    assign drv_fwd   = (state_q == RUN_MOVE) && (dir_q != BACK);
    assign busy      = running;
    assign done      = last;
    assign cmd_err   = err_q;
    assign heading   = heading_q;

endmodule

// File: tb/tb_motion_executor.sv
// tb_motion_executor: directed bench for motion_executor with
// TICK_DIV=4, TURN_TICKS=5, MOVE_TICKS=3, WAIT_TICKS=2.
// A cycle-count reference model (remaining cycles per command, derived from
// the command-length rules) is compared against every output on every
// falling edge; directed sequences add hand-computed literal expectations.
// With MOTION_QUEUE_EN defined the model and a buffered-command scenario
// follow the one-entry queue behaviour.
module tb_motion_executor;
    import motion_pkg::*;

    localparam int TDIV = 4;
`ifdef MOTION_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_state;
    logic [3:0] cmd_dir;
    logic       cmd_ready, drv_fwd, drv_back, drv_left, drv_right;
    logic       busy, done, cmd_err;
    logic [1:0] heading;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    motion_executor #(
        .TICK_DIV   (TDIV),
        .TURN_TICKS (5),
        .MOVE_TICKS (3),
        .WAIT_TICKS (2)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_state (cmd_state),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .drv_fwd   (drv_fwd),
        .drv_back  (drv_back),
        .drv_left  (drv_left),
        .drv_right (drv_right),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err),
        .heading   (heading)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_rem  = 0;      // RUN cycles still to show, including current
    logic [1:0] m_st   = WAIT;
    logic [3:0] m_dir  = 4'b0;
    logic [1:0] m_head = 2'd0;
    bit         m_err  = 1'b0;
    bit         m_pend = 1'b0;
    logic [1:0] m_pend_st;
    logic [3:0] m_pend_dir;
    bit         m_busy_b, m_ready_b, m_acc, m_ok, m_fin;

    function automatic int model_ticks(input logic [1:0] st, input logic [3:0] dir);
        if (st == TURN) begin
            if (dir == FRONT) return 0;
            if (dir == BACK) return 10;
            return 5;
        end
        if (st == MOVE) return 3;
        return 2;
    endfunction

    function automatic logic [1:0] model_turn(input logic [1:0] st, input logic [3:0] dir);
        if (st != TURN) return 2'd0;
        if (dir == RIGHT) return 2'd1;
        if (dir == LEFT) return 2'd3;
        if (dir == BACK) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_start(input logic [1:0] st, input logic [3:0] dir);
        int d;
        d     = model_ticks(st, dir) * TDIV;
        m_st  = st;
        m_dir = dir;
        m_rem = (d == 0) ? 1 : d;
    endtask

    initial forever begin
        @(posedge sys_clk or posedge rst);
        if (rst) begin
            m_rem = 0; m_pend = 1'b0; m_head = 2'd0; m_err = 1'b0;
        end else begin
            m_busy_b  = (m_rem > 0);
            m_ready_b = QUEUE ? !m_pend : !m_busy_b;
            m_acc     = cmd_valid && m_ready_b;
            m_ok      = (cmd_state != 2'b11) && ($countones(cmd_dir) == 1);
            m_fin     = (m_rem == 1);
            m_err     = m_acc && !m_ok;
            if (m_busy_b) begin
                if (m_fin) m_head = m_head + model_turn(m_st, m_dir);
                m_rem = m_rem - 1;
            end
            if (m_pend && (!m_busy_b || m_fin)) begin
                model_start(m_pend_st, m_pend_dir);
                m_pend = 1'b0;
            end else if (m_acc && m_ok) begin
                if (m_busy_b) begin
                    m_pend = 1'b1; m_pend_st = cmd_state; m_pend_dir = cmd_dir;
                end else begin
                    model_start(cmd_state, cmd_dir);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge sys_clk);
        if (cmp_en && !rst) begin
            check("cyc_busy",  busy,      m_rem > 0);
            check("cyc_done",  done,      m_rem == 1);
            check("cyc_ready", cmd_ready, QUEUE ? !m_pend : (m_rem == 0));
            check("cyc_err",   cmd_err,   m_err);
            check("cyc_head",  heading,   m_head);
            check("cyc_left",  drv_left,  (m_rem > 0) && m_st == TURN && m_dir == LEFT);
            check("cyc_right", drv_right, (m_rem > 0) && m_st == TURN && (m_dir == RIGHT || m_dir == BACK));
            check("cyc_back",  drv_back,  (m_rem > 0) && m_st == MOVE && m_dir == BACK);
            check("cyc_fwd",   drv_fwd,   (m_rem > 0) && m_st == MOVE && m_dir != BACK);
        end
    end

    // ---------------- directed sequences ----------------
    task automatic run_cmd(input string name, input logic [1:0] st, input logic [3:0] dir,
                           input int e_fwd, input int e_back, input int e_left, input int e_right,
                           input int e_busy, input int e_done_at, input logic [1:0] e_head);
        int n_fwd, n_back, n_left, n_right, n_busy, done_at;
        n_fwd = 0; n_back = 0; n_left = 0; n_right = 0; n_busy = 0; done_at = -1;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_state = st; cmd_dir = dir;
        for (int i = 1; i <= 100; i++) begin
            @(negedge sys_clk);
            n_fwd += int'(drv_fwd); n_back += int'(drv_back);
            n_left += int'(drv_left); n_right += int'(drv_right);
            n_busy += int'(busy);
            if (i == 1) begin
                // Junk after acceptance must not affect the running command.
                cmd_valid = 1'b0; cmd_state = 2'b11; cmd_dir = 4'b1111;
            end
            if (done) begin
                done_at = i;
                break;
            end
        end
        check({name, "_fwd"},     n_fwd,   e_fwd);
        check({name, "_back"},    n_back,  e_back);
        check({name, "_left"},    n_left,  e_left);
        check({name, "_right"},   n_right, e_right);
        check({name, "_busy"},    n_busy,  e_busy);
        check({name, "_done_at"}, done_at, e_done_at);
        @(negedge sys_clk);
        check({name, "_ready_after"}, cmd_ready, 1);
        check({name, "_idle_after"},  busy,      0);
        check({name, "_heading"},     heading,   e_head);
    endtask

    task automatic run_illegal(input string name, input logic [1:0] st, input logic [3:0] dir,
                               input logic [1:0] e_head);
        int n_busy, n_done;
        n_busy = 0; n_done = 0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_state = st; cmd_dir = dir;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        check({name, "_err_pulse"}, cmd_err, 1);
        check({name, "_no_busy"},   busy,    0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            if (i == 0) check({name, "_err_clear"}, cmd_err, 0);
            n_busy += int'(busy);
            n_done += int'(done);
        end
        check({name, "_busy_cnt"}, n_busy,  0);
        check({name, "_done_cnt"}, n_done,  0);
        check({name, "_heading"},  heading, e_head);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int n_fwd;
        int done_at;
        rst = 1'b1; cmd_valid = 1'b0; cmd_state = WAIT; cmd_dir = FRONT;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge sys_clk);
        check("reset_ready", cmd_ready, 1);
        check("reset_drv",   {drv_fwd, drv_back, drv_left, drv_right}, 0);
        check("reset_flags", {busy, done, cmd_err}, 0);
        check("reset_head",  heading, 0);

        //       name          state dir    fwd back left right busy done head
        run_cmd("turn_right", TURN, RIGHT,  0,  0,   0,   20,   20,  20,  2'd1);
        run_cmd("turn_left1", TURN, LEFT,   0,  0,   20,  0,    20,  20,  2'd0);
        run_cmd("turn_left0", TURN, LEFT,   0,  0,   20,  0,    20,  20,  2'd3);
        run_cmd("turn_back",  TURN, BACK,   0,  0,   0,   40,   40,  40,  2'd1);
        run_cmd("move_front", MOVE, FRONT,  12, 0,   0,   0,    12,  12,  2'd1);
        run_cmd("move_back",  MOVE, BACK,   0,  12,  0,   0,    12,  12,  2'd1);
        run_cmd("wait",       WAIT, LEFT,   0,  0,   0,   0,    8,   8,   2'd1);
        run_cmd("turn_front", TURN, FRONT,  0,  0,   0,   0,    1,   1,   2'd1);

        run_illegal("ill_state", 2'b11, FRONT,   2'd1);
        run_illegal("ill_dir",   MOVE,  4'b0110, 2'd1);

        // Reset in the middle of a turn.
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_state = TURN; cmd_dir = RIGHT;
        for (int i = 1; i <= 7; i++) begin
            @(negedge sys_clk);
            if (i == 1) cmd_valid = 1'b0;
        end
        check("rst_mid_drv_before", drv_right, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_drv_async", drv_right, 0);
        check("rst_mid_busy",      busy,      0);
        check("rst_mid_ready",     cmd_ready, 1);
        check("rst_mid_head",      heading,   0);
        @(negedge sys_clk);
        rst = 1'b0;
        n_done = 0;
        repeat (25) begin
            @(negedge sys_clk);
            n_done += int'(done);
        end
        check("rst_mid_no_done", n_done,  0);
        check("rst_mid_head2",   heading, 0);

`ifndef MOTION_QUEUE_EN
        // Held-valid back-to-back MOVEs: runs in cycles 1..12 and 14..25.
        n_fwd = 0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_state = MOVE; cmd_dir = FRONT;
        for (int i = 1; i <= 26; i++) begin
            @(negedge sys_clk);
            n_fwd += int'(drv_fwd);
            if (i == 12) check("b2b_fwd_c12", drv_fwd, 1);
            if (i == 13) begin
                check("b2b_gap_fwd",   drv_fwd,   0);
                check("b2b_gap_ready", cmd_ready, 1);
            end
            if (i == 14) check("b2b_fwd_c14", drv_fwd, 1);
            if (i == 26) cmd_valid = 1'b0;
        end
        check("b2b_fwd_total", n_fwd, 24);
`else
        // A MOVE offered mid-turn is buffered and follows the turn directly.
        done_at = -1;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_state = TURN; cmd_dir = RIGHT;
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            if (i == 1) cmd_valid = 1'b0;
            if (i == 5) begin
                cmd_valid = 1'b1; cmd_state = MOVE; cmd_dir = FRONT;
            end
            if (i == 6) begin
                check("q_ready_full", cmd_ready, 0);
                cmd_valid = 1'b0;
            end
            if (done && done_at < 0) done_at = i;
            if (i == 20) check("q_turn_drv_last", drv_right, 1);
            if (i == 21) begin
                check("q_fwd_follows", drv_fwd, 1);
                check("q_busy_follows", busy,   1);
            end
        end
        check("q_turn_done_at", done_at, 20);
        check("q_heading",      heading, 1);
`endif

        repeat (2) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/motion_executor.md
Name: motion_executor

Overview:
- Car-side consumer of the maze controller's command stream.
- Accepts one command at a time as a (state, direction) pair:
  - state: MOVE / TURN / WAIT.
  - direction: one-hot front / back / right / left.
- Executes each command as a timed drive pattern on the four motor-control outputs, then pulses done.
- Tracks absolute heading so the controller and display can read it.

Parameters:
- TICK_DIV, 2000000: sys_clk cycles per motion tick (20 ms at 100 MHz).
- TURN_TICKS, 5: ticks for one 90-degree turn.
- MOVE_TICKS, 3: ticks for one forward/backward move step.
- WAIT_TICKS, 1: ticks for a WAIT command.

Ports:
- sys_clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- cmd_valid, in, 1: command present.
- cmd_state, in, 2: 2'b10 MOVE, 2'b01 TURN, 2'b00 WAIT, 2'b11 illegal.
- cmd_dir, in, 4: one-hot; 0001 front, 0010 back, 0100 right, 1000 left.
- cmd_ready, out, 1: executor can accept a command.
- drv_fwd, out, 1: drive forward.
- drv_back, out, 1: drive backward.
- drv_left, out, 1: rotate left.
- drv_right, out, 1: rotate right.
- busy, out, 1: executing a command.
- done, out, 1: one-cycle pulse at command completion.
- cmd_err, out, 1: one-cycle pulse on an illegal command.
- heading, out, 2: 0 N, 1 E, 2 S, 3 W.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All drv_* = 0, busy = 0, done = 0, cmd_err = 0, heading = 0.
  - cmd_ready = 1.
  - Tick divider and tick counter cleared.
  - Asserting reset mid-command aborts the command immediately; no done pulse is produced.
- Handshake:
  - A command is accepted on a sys_clk edge where cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE.
  - cmd_state and cmd_dir are registered at acceptance; later input changes are ignored.
- Illegal command: cmd_state = 11, or cmd_dir not exactly one-hot.
  - The command is still accepted.
  - cmd_err pulses in the next cycle.
  - FSM stays in IDLE; no done pulse; heading unchanged.
- FSM states: IDLE, RUN_TURN, RUN_MOVE, RUN_WAIT.
- Entering a RUN state:
  - Occurs on the edge after acceptance.
  - The tick divider restarts at 0.
  - Duration is exactly D = N*TICK_DIV cycles, where N is:
    - TURN_TICKS for left or right turns.
    - 2*TURN_TICKS for a back turn.
    - MOVE_TICKS for MOVE.
    - WAIT_TICKS for WAIT.
- Outputs per state:
  - RUN_TURN, left: drv_left = 1.
  - RUN_TURN, right or back: drv_right = 1.
  - RUN_TURN, front: zero-length; no drv output asserted; done pulses in the cycle after acceptance.
  - RUN_MOVE, back: drv_back = 1.
  - RUN_MOVE, any other direction: drv_fwd = 1.
  - RUN_WAIT: all drv_* = 0.
  - busy = 1 in every RUN state.
  - At most one drv_* is ever high.
- Completion:
  - done pulses during the last of the D cycles; that is the final cycle drv_* is high.
  - On the following edge, FSM returns to IDLE with cmd_ready = 1.
  - Back-to-back commands therefore have exactly one IDLE cycle between them.
- Heading update (mod 4), on the done cycle:
  - right +1, left -1 (wrap 0 -> 3), back +2.
  - Front turn, MOVE and WAIT leave heading unchanged.
- Counters:
  - Divider width is $clog2(TICK_DIV).
  - Tick counter width is $clog2(2*TURN_TICKS+1).
  - No overflow is possible.
  - A parameter value of 0 is illegal.

Optional Feature:
- MOTION_QUEUE_EN defined:
  - Adds a one-entry command buffer.
  - cmd_ready = 1 in IDLE and in RUN states while the buffer is empty.
  - A buffered command starts on the edge after done, with no IDLE cycle.
  - Simultaneous accept and done on the same edge: the buffer is loaded, and the next command starts on the following edge.
  - Illegal commands are rejected at buffer entry: cmd_err pulses and the buffer is not loaded.
- MOTION_QUEUE_EN not defined: behaviour exactly as above.

Decomposition:
- Shared package motion_pkg holds:
  - State codes MOVE = 2'b10, TURN = 2'b01, WAIT = 2'b00 (shared with the controller's next_state encoding).
  - Direction one-hots FRONT, BACK, RIGHT, LEFT.
  - Heading enum N/E/S/W.
  - Default tick constants.
- Sub-module tick_gen(TICK_DIV):
  - Inputs: sys_clk, rst, restart.
  - Output: a one-cycle tick pulse.

Test Plan (TICK_DIV=4, TURN_TICKS=5, MOVE_TICKS=3, WAIT_TICKS=2):
- Reset then idle: all outputs 0, cmd_ready = 1, heading = 0.
- TURN right accepted at edge 0:
  - drv_right high for cycles 1..20.
  - done at cycle 20, heading = 1.
  - cmd_ready = 1 at cycle 21.
- TURN left from heading 0: drv_left high for 20 cycles, heading = 3.
- TURN back: drv_right high for 40 cycles, heading += 2.
- MOVE front: drv_fwd high for 12 cycles.
- MOVE back: drv_back high for 12 cycles; heading unchanged.
- WAIT: busy high for 8 cycles with no drv_* asserted.
- cmd_state = 11 or cmd_dir = 0110: cmd_err pulse one cycle later, no busy, no done.
- rst asserted at cycle 7 of a turn: drv_right drops asynchronously, no done, heading = 0.
- MOTION_QUEUE_EN: second MOVE offered during a TURN is accepted; drv_fwd rises in the cycle right after the turn's done.
